txs_burst_sink: RTL and testbench
=================================

// Module: txs_burst_sink
// PURPOSE
//  Avalon-MM burst-write responder for the 128-bit TXS interface driven by top.
//  Accepts txs_write bursts, applies programmable waitrequest backpressure, and
//  forwards each beat (word address + data) through a small FIFO to a memory
//  write port. Reports burst completion, beat counts and sticky protocol errors.
//  Sits opposite top's TXS master, in benches and in loopback builds.
// PARAMETERS
//  FIFO_DEPTH  4   output FIFO entries (power of 2, >=4)
//  MAX_BURST   32  largest legal burstcount; larger is flagged but accepted
// PORTS
//  c                input   1    clock
//  rst_n            input   1    asynchronous active-low reset
//  txs_write        input   1    write request, qualified by ~txs_waitrequest
//  txs_address      input   23   byte address, sampled on first beat only
//  txs_burstcount   input   6    beats in burst, sampled on first beat only
//  txs_writedata    input   128  beat data
//  txs_waitrequest  output  1    registered backpressure to master
//  stall_pattern    input   16   rotating stall mask, bit=1 -> stall that cycle
//  out_valid        output  1    FIFO head valid
//  out_ready        input   1    consumer takes head when out_valid&out_ready
//  out_addr         output  19   word address (byte address >> 4)
//  out_data         output  128  beat data
//  burst_done       output  1    1-cycle pulse when last beat of a burst is accepted
//  burst_base       output  23   byte address of completed burst, held until next done
//  burst_len        output  6    burstcount of completed burst, held until next done
//  beat_count       output  32   total accepted beats, wraps modulo 2^32
//  err_flags        output  3    sticky: [0] burstcount 0, [1] addr[3:0]!=0, [2] burstcount>MAX_BURST
//  err_clr          input   1    clears err_flags (set has priority in same cycle)
// BEHAVIOUR
//  Reset: txs_waitrequest=1, out_valid=0, burst_done=0, burst_base=0, burst_len=0,
//   beat_count=0, err_flags=0, state=IDLE, FIFO empty, pattern index=0.
//  Accept = txs_write & ~txs_waitrequest.
//  txs_waitrequest (registered) next = stall_pattern[idx] | (fifo_count_next >= FIFO_DEPTH-1);
//   idx increments every cycle, wraps 15->0. Registered flag guarantees an
//   accepted beat always has a free FIFO slot.
//  FSM IDLE: on accept latch base=txs_address, len=txs_burstcount, wptr=address>>4.
//   burstcount==0: set err[0], beat dropped (no FIFO write, no count), stay IDLE.
//   address[3:0]!=0: set err[1], proceed with address>>4 (low bits discarded).
//   burstcount>MAX_BURST: set err[2], proceed normally.
//   Write beat to FIFO at wptr; remaining=len-1; remaining==0 -> burst_done, stay
//   IDLE; else -> BURST, wptr+=1.
//  FSM BURST: each accept writes beat at wptr, wptr+=1 (19-bit wrap 0x7FFFF->0),
//   remaining-=1; address/burstcount inputs ignored. Last beat -> burst_done
//   pulse next cycle, burst_base/len updated same cycle, -> IDLE.
//  txs_write low mid-burst: hold state indefinitely, no timeout.
//  Latency: accepted beat visible on out_* the cycle after accept (out_valid=1).
//  FIFO: simultaneous push and pop when full-1 or empty both legal; pop on empty
//   is impossible (out_valid gates). out_* hold stable while out_valid&~out_ready.
//  beat_count increments once per FIFO push.
//  rst_n low at any time (incl. mid-burst): async return to reset values, FIFO
//   flushed, partial burst discarded without burst_done.
// TESTING
//  1 stall_pattern=0, out_ready=1, burst addr 0x000100 cnt 4 -> out_addr 0x10..0x13
//    in order, one burst_done, burst_base=0x000100, burst_len=4, beat_count=4.
//  2 stall_pattern=16'hAAAA, burst cnt 8 -> waitrequest toggles every cycle, 8 beats
//    accepted in 16 cycles, data order preserved, burst_done once.
//  3 out_ready=0, burst cnt 8, FIFO_DEPTH=4 -> waitrequest=1 after 3 beats, no data
//    loss; release out_ready -> all 8 beats drain in order.
//  4 first beat burstcount=0 -> err_flags=3'b001, no FIFO write, beat_count
//    unchanged; err_clr pulse -> err_flags=0.
//  5 addr 0x7FFFF0 cnt 3 -> out_addr 0x7FFFF,0x00000,0x00001;
//    addr 0x000108 -> err[1] set.
//  6 rst_n low after 2 of 6 beats -> outputs at reset values, no burst_done;
//    new burst cnt 2 after release completes normally with beat_count=2.

Source files
------------

// File: rtl/txs_burst_sink.sv
// -----------------------------------------------------------------------------
// txs_burst_sink
//   Avalon-MM burst-write responder for the 128-bit TXS interface. It accepts
//   txs_write bursts, throttles the master with a registered waitrequest
//   (a rotating stall mask plus FIFO occupancy), and forwards every accepted
//   beat as {word address, data} through a small FIFO to a memory write port.
//   It also reports burst completion, a running beat count and sticky
//   protocol error flags.
//
// Ports
//   c                in   clock
//   rst_n            in   asynchronous active-low reset
//   txs_write        in   write request, qualified by ~txs_waitrequest
//   txs_address      in   [22:0] byte address, sampled on the first beat only
//   txs_burstcount   in   [5:0] beats in burst, sampled on the first beat only
//   txs_writedata    in   [127:0] beat data
//   txs_waitrequest  out  registered backpressure to the master
//   stall_pattern    in   [15:0] rotating stall mask, bit=1 stalls that cycle
//   out_valid        out  FIFO head valid
//   out_ready        in   consumer takes the head when out_valid & out_ready
//   out_addr         out  [18:0] word address (byte address >> 4)
//   out_data         out  [127:0] beat data
//   burst_done       out  1-cycle pulse after the last beat of a burst
//   burst_base       out  [22:0] byte address of the last completed burst
//   burst_len        out  [5:0] burstcount of the last completed burst
//   beat_count       out  [31:0] total accepted beats, wraps modulo 2^32
//   err_flags        out  [2:0] sticky: [0] burstcount 0, [1] unaligned
//                         address, [2] burstcount > MAX_BURST
//   err_clr          in   clears err_flags (a new error in the same cycle wins)
// -----------------------------------------------------------------------------
module txs_burst_sink #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 32
) (
  input  logic         c,
  input  logic         rst_n,
  input  logic         txs_write,
  input  logic [22:0]  txs_address,
  input  logic [5:0]   txs_burstcount,
  input  logic [127:0] txs_writedata,
  output logic         txs_waitrequest,
  input  logic [15:0]  stall_pattern,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [18:0]  out_addr,
  output logic [127:0] out_data,
  output logic         burst_done,
  output logic [22:0]  burst_base,
  output logic [5:0]   burst_len,
  output logic [31:0]  beat_count,
  output logic [2:0]   err_flags,
  input  logic         err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  // Stall once the FIFO would hold DEPTH-1 entries: because waitrequest is
  // registered, one more beat can still land the cycle the flag rises.
  localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - 1);
  localparam logic [5:0]    MAX_BC    = 6'(MAX_BURST);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Control state
  state_t          state_q, state_d;
  logic [3:0]      idx_q;
  logic            wreq_q, wreq_d;
  logic [18:0]     wptr_q, wptr_d;
  logic [5:0]      remain_q, remain_d;
  logic [22:0]     base_q, base_d;
  logic [5:0]      len_q, len_d;
  logic            done_q;
  logic [22:0]     done_base_q, done_base_d;
  logic [5:0]      done_len_q, done_len_d;
  logic [31:0]     beat_cnt_q;
  logic [2:0]      err_q, err_d, err_set;

  // FIFO
  logic [146:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;

  logic            accept;
  logic            push;
  logic            pop;
  logic            last_beat;
  logic [18:0]     push_addr;

  assign accept = txs_write & ~wreq_q;
  assign pop    = (count_q != '0) & out_ready;

  // Next-state / burst bookkeeping
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    remain_d    = remain_q;
    base_d      = base_q;
    len_d       = len_q;
    push        = 1'b0;
    push_addr   = wptr_q;
    last_beat   = 1'b0;
    err_set     = 3'b000;
    done_base_d = base_q;
    done_len_d  = len_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          base_d = txs_address;
          len_d  = txs_burstcount;
          if (txs_burstcount == 6'd0) begin
            // Zero-length burst: flag it and drop the beat entirely.
            err_set[0] = 1'b1;
          end else begin
            if (txs_address[3:0] != 4'd0) err_set[1] = 1'b1;
            if (txs_burstcount > MAX_BC)  err_set[2] = 1'b1;
            push        = 1'b1;
            push_addr   = txs_address[22:4];
            wptr_d      = txs_address[22:4] + 19'd1;
            remain_d    = txs_burstcount - 6'd1;
            done_base_d = txs_address;
            done_len_d  = txs_burstcount;
            if (txs_burstcount == 6'd1) begin
              last_beat = 1'b1;
            end else begin
              state_d = BURST;
            end
          end
        end
      end

      BURST: begin
        // Address/burstcount inputs are ignored until the burst completes.
        if (accept) begin
          push      = 1'b1;
          push_addr = wptr_q;
          wptr_d    = wptr_q + 19'd1;
          remain_d  = remain_q - 6'd1;
          if (remain_q == 6'd1) begin
            last_beat = 1'b1;
            state_d   = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    wreq_d  = stall_pattern[idx_q] | (count_d >= STALL_LVL);
    // A set in the same cycle as a clear survives.
    err_d   = (err_clr ? 3'b000 : err_q) | err_set;
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      wreq_q      <= 1'b1;
      wptr_q      <= '0;
      remain_q    <= '0;
      base_q      <= '0;
      len_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      done_base_q <= '0;
      done_len_q  <= '0;
      beat_cnt_q  <= '0;
      err_q       <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_q + 4'd1;
      wreq_q   <= wreq_d;
      wptr_q   <= wptr_d;
      remain_q <= remain_d;
      base_q   <= base_d;
      len_q    <= len_d;
      count_q  <= count_d;
      err_q    <= err_d;
      done_q   <= last_beat;
      if (last_beat) begin
        done_base_q <= done_base_d;
        done_len_q  <= done_len_d;
      end
      if (push) begin
        wr_ptr_q   <= wr_ptr_q + AW'(1);
        beat_cnt_q <= beat_cnt_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // FIFO storage carries data only, so it is left out of reset.
  always_ff @(posedge c) begin
    if (push) begin
      mem[wr_ptr_q] <= {push_addr, txs_writedata};
    end
  end

  assign txs_waitrequest      = wreq_q;
  assign out_valid            = (count_q != '0);
  assign {out_addr, out_data} = mem[rd_ptr_q];
  assign burst_done           = done_q;
  assign burst_base           = done_base_q;
  assign burst_len            = done_len_q;
  assign beat_count           = beat_cnt_q;
  assign err_flags            = err_q;

endmodule

// File: tb/tb_txs_burst_sink.sv
// -----------------------------------------------------------------------------
// tb_txs_burst_sink
//   Scoreboard bench for txs_burst_sink. A reference model watches accepted
//   beats and queues the expected FIFO output and burst completions; an
//   independent monitor compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_txs_burst_sink;
  localparam int FIFO_DEPTH = 4;
  localparam int MAX_BURST  = 32;

  logic         c = 1'b0;
  logic         rst_n = 1'b0;
  logic         txs_write = 1'b0;
  logic [22:0]  txs_address = '0;
  logic [5:0]   txs_burstcount = '0;
  logic [127:0] txs_writedata = '0;
  logic         txs_waitrequest;
  logic [15:0]  stall_pattern = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [18:0]  out_addr;
  logic [127:0] out_data;
  logic         burst_done;
  logic [22:0]  burst_base;
  logic [5:0]   burst_len;
  logic [31:0]  beat_count;
  logic [2:0]   err_flags;
  logic         err_clr = 1'b0;

  always #5 c = ~c;

  txs_burst_sink #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .c(c), .rst_n(rst_n), .txs_write(txs_write), .txs_address(txs_address),
    .txs_burstcount(txs_burstcount), .txs_writedata(txs_writedata),
    .txs_waitrequest(txs_waitrequest), .stall_pattern(stall_pattern),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .burst_done(burst_done), .burst_base(burst_base),
    .burst_len(burst_len), .beat_count(beat_count), .err_flags(err_flags),
    .err_clr(err_clr)
  );

  typedef struct packed { logic [18:0] addr; logic [127:0] data; } beat_t;
  typedef struct packed { logic [22:0] base; logic [5:0] len; } done_t;

  int checks = 0;
  int failures = 0;

  beat_t exp_q[$];
  done_t done_q[$];

  // Reference model state
  bit          m_in_burst = 0;
  logic [18:0] m_addr = '0;
  int          m_left = 0;
  logic [22:0] m_base = '0;
  logic [5:0]  m_len = '0;
  logic [31:0] m_beats = '0;
  logic [2:0]  m_err = '0;
  bit          m_pushed = 0;
  int          acc_total = 0;

  // Monitor state
  logic [22:0] last_base = '0;
  logic [5:0]  last_len = '0;
  int          done_seen = 0;
  bit          prev_hold = 0;
  bit          prev_pushed = 0;

  int rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Reference model: a beat is taken whenever write is high and waitrequest low.
  always @(negedge c) begin
    beat_t b;
    done_t d;
    m_pushed = 0;
    if (rst_n) begin
      if (err_clr) m_err = 3'b000;
      if (txs_write && !txs_waitrequest) begin
        acc_total++;
        if (!m_in_burst) begin
          if (txs_burstcount == 6'd0) begin
            m_err[0] = 1'b1;
          end else begin
            if (txs_address[3:0] != 4'd0) m_err[1] = 1'b1;
            if (int'(txs_burstcount) > MAX_BURST) m_err[2] = 1'b1;
            m_in_burst = 1;
            m_addr = 19'(txs_address >> 4);
            m_left = int'(txs_burstcount);
            m_base = txs_address;
            m_len  = txs_burstcount;
          end
        end
        if (m_in_burst) begin
          b.addr = m_addr;
          b.data = txs_writedata;
          exp_q.push_back(b);
          m_pushed = 1;
          m_addr = m_addr + 19'd1;
          m_left--;
          m_beats = m_beats + 32'd1;
          if (m_left == 0) begin
            d.base = m_base;
            d.len  = m_len;
            done_q.push_back(d);
            m_in_burst = 0;
          end
        end
      end
    end
  end

  // Monitor: compares the FIFO head and burst completions against the queues.
  always @(negedge c) begin
    beat_t e;
    done_t d;
    #1;
    if (!rst_n) begin
      prev_hold = 0;
      prev_pushed = 0;
    end else begin
      if (prev_hold) chk("hold_valid", out_valid, 1'b1);
      if (prev_pushed) chk("latency_valid", out_valid, 1'b1);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 1'b1, 1'b0);
        end else begin
          e = exp_q[0];
          chk("beat_addr", out_addr, e.addr);
          chk("beat_data", out_data, e.data);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (burst_done) begin
        done_seen++;
        if (done_q.size() == 0) begin
          chk("done_unexpected", 1'b1, 1'b0);
        end else begin
          d = done_q.pop_front();
          chk("done_base", burst_base, d.base);
          chk("done_len", burst_len, d.len);
          last_base = d.base;
          last_len  = d.len;
        end
      end
      prev_hold   = out_valid && !out_ready;
      prev_pushed = m_pushed;
    end
  end

  always @(posedge c) begin
    #1;
    case (rdy_mode)
      1: out_ready = 1'b1;
      2: out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 2) != 0);
    endcase
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [22:0] a, input logic [5:0] bc,
                           input logic [127:0] d, inout int cyc);
    bit acc;
    int n;
    acc = 0;
    n = 0;
    txs_write = 1'b1;
    txs_address = a;
    txs_burstcount = bc;
    txs_writedata = d;
    while (!acc) begin
      @(negedge c);
      acc = !txs_waitrequest;
      n++;
      @(posedge c); #1;
      if (!acc && n > 300) begin
        chk("accept_timeout", 1'b0, 1'b1);
        acc = 1;
      end
    end
    cyc += n;
    txs_write = 1'b0;
  endtask

  task automatic do_burst(input logic [22:0] a, input logic [5:0] bc, input int nsend,
                          input bit gaps, output int cyc);
    logic [22:0] aa;
    logic [5:0]  bb;
    cyc = 0;
    for (int i = 0; i < nsend; i++) begin
      aa = (i == 0) ? a : 23'($urandom);
      bb = (i == 0) ? bc : 6'($urandom);
      send_beat(aa, bb, {$urandom, $urandom, $urandom, $urandom}, cyc);
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge c); #1;
      end
    end
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge c); #1;
      n++;
    end
    chk("drain_in_time", n < 500, 1'b1);
    repeat (2) @(posedge c);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_beat_count"}, beat_count, m_beats);
    chk({tag, "_err"}, err_flags, m_err);
    chk({tag, "_base"}, burst_base, last_base);
    chk({tag, "_len"}, burst_len, last_len);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_waitreq"}, txs_waitrequest, 1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_done"}, burst_done, 1'b0);
    chk({tag, "_base"}, burst_base, 23'd0);
    chk({tag, "_len"}, burst_len, 6'd0);
    chk({tag, "_beat_count"}, beat_count, 32'd0);
    chk({tag, "_err"}, err_flags, 3'd0);
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(posedge c); #1;
    err_clr = 1'b0;
    @(posedge c); #1;
  endtask

  task automatic model_reset();
    exp_q.delete();
    done_q.delete();
    m_in_burst = 0;
    m_beats = '0;
    m_err = '0;
    last_base = '0;
    last_len = '0;
  endtask

  initial begin
    int cyc;
    int d0;
    int a0;
    logic [22:0] ra;

    // Reset state
    rdy_mode = 1;
    repeat (3) @(posedge c);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge c);
    #1;

    // T1: simple 4-beat burst, no stalls
    d0 = done_seen;
    do_burst(23'h000100, 6'd4, 4, 0, cyc);
    wait_quiet();
    chk("t1_done_count", done_seen - d0, 1);
    chk("t1_base", burst_base, 23'h000100);
    chk("t1_len", burst_len, 6'd4);
    chk("t1_beat_count", beat_count, 32'd4);
    chk_state("t1");

    // T2: alternating stall mask, 8 beats
    stall_pattern = 16'hAAAA;
    d0 = done_seen;
    ra = {19'($urandom), 4'h0};
    do_burst(ra, 6'd8, 8, 0, cyc);
    chk("t2_cycles_ok", (cyc == 15 || cyc == 16), 1'b1);
    wait_quiet();
    chk("t2_done_count", done_seen - d0, 1);
    chk_state("t2");

    // T3: consumer blocked, FIFO fills to DEPTH-1 then stalls
    stall_pattern = 16'h0000;
    rdy_mode = 2;
    repeat (2) @(posedge c);
    #1;
    a0 = acc_total;
    fork
      do_burst({19'($urandom), 4'h0}, 6'd8, 8, 0, cyc);
      begin
        repeat (12) @(negedge c);
        #2;
        chk("t3_accepted", acc_total - a0, FIFO_DEPTH - 1);
        chk("t3_waitreq", txs_waitrequest, 1'b1);
        rdy_mode = 1;
      end
    join
    wait_quiet();
    chk_state("t3");

    // T4: zero burstcount, then clear
    rdy_mode = 0;
    cyc = 0;
    send_beat(23'h000200, 6'd0, {4{32'hDEADBEEF}}, cyc);
    repeat (3) @(posedge c);
    #1;
    chk("t4_err", err_flags, 3'b001);
    chk("t4_beat_count", beat_count, m_beats);
    chk("t4_no_beat", out_valid, 1'b0);
    clear_errors();
    chk("t4_err_clr", err_flags, 3'b000);

    // T5: word-address wrap, unaligned address, burstcount limits
    do_burst(23'h7FFFF0, 6'd3, 3, 1, cyc);
    wait_quiet();
    chk("t5_wrap_err", err_flags, 3'b000);
    chk_state("t5a");
    do_burst(23'h000108, 6'd2, 2, 1, cyc);
    wait_quiet();
    chk("t5_unaligned_err", err_flags, 3'b010);
    chk_state("t5b");
    clear_errors();
    do_burst(23'h001000, 6'd32, 32, 1, cyc);
    wait_quiet();
    chk("t5_max_ok", err_flags, 3'b000);
    stall_pattern = 16'h3C5A;
    do_burst(23'h002000, 6'd40, 40, 1, cyc);
    wait_quiet();
    chk("t5_over_max", err_flags, 3'b100);
    chk_state("t5c");
    clear_errors();

    // Randomised bursts
    for (int k = 0; k < 15; k++) begin
      stall_pattern = 16'($urandom) & ~16'h0101;
      ra = 23'($urandom);
      if ($urandom_range(0, 3) != 0) ra[3:0] = 4'h0;
      do_burst(ra, 6'($urandom_range(1, 12)), 0, 1, cyc);
      cyc = 0;
      d0 = $urandom_range(1, 12);
      do_burst(ra, 6'(d0), d0, 1, cyc);
      wait_quiet();
      chk_state("rand");
    end
    clear_errors();
    chk("rand_err_clr", err_flags, 3'b000);

    // T6: reset in the middle of a burst
    stall_pattern = 16'h0000;
    rdy_mode = 1;
    d0 = done_seen;
    do_burst(23'h000300, 6'd6, 2, 0, cyc);
    rst_n = 1'b0;
    model_reset();
    #3;
    chk_reset("t6_reset");
    repeat (2) @(posedge c);
    #1;
    chk("t6_no_done", done_seen - d0, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge c);
    #1;
    do_burst(23'h000400, 6'd2, 2, 0, cyc);
    wait_quiet();
    chk("t6_beat_count", beat_count, 32'd2);
    chk("t6_base", burst_base, 23'h000400);
    chk("t6_len", burst_len, 6'd2);
    chk("t6_done_count", done_seen - d0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
